// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bit-serial system bus endpoints:
//   - default address / data / burst-count field widths
//   - slave_port FSM state encoding (plain localparam constants)
//   - transaction direction enum
//   - start-condition helper used by the slave idle decode
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_ADDR_LEN  = 12;
    localparam int BUS_DATA_LEN  = 8;
    localparam int BUS_BURST_LEN = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_RFETCH = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_e;

    // A transaction starts only when exactly one direction is requested.
    function automatic logic bus_start(input logic sel, input logic valid,
                                       input logic wr, input logic rd);
        return sel & valid & (wr ^ rd);
    endfunction

endpackage

// File: rtl/slave_memory.sv
// -----------------------------------------------------------------------------
// slave_memory
// Single-port synchronous RAM, 2^ADDR_LEN x DATA_LEN. Writes are registered;
// reads return the addressed word one clock after i_re. A write takes the
// port in preference to a read in the same cycle. Contents are never reset.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_re     in   read enable
//   i_addr   in   word address
//   i_wdata  in   write word
//   o_rdata  out  registered read word
// -----------------------------------------------------------------------------
module slave_memory
    import bus_pkg::*;
#(
    parameter int ADDR_LEN = BUS_ADDR_LEN,
    parameter int DATA_LEN = BUS_DATA_LEN
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [ADDR_LEN-1:0] i_addr,
    input  logic [DATA_LEN-1:0] i_wdata,
    output logic [DATA_LEN-1:0] o_rdata
);

    logic [DATA_LEN-1:0] r_mem [0:(1 << ADDR_LEN)-1];
    logic [DATA_LEN-1:0] r_rdata;

    // RAM array write and registered read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
// Bit-serial slave endpoint. Deserialises address / burst count / write data
// (all LSB first) from the master, performs single or burst writes into a
// local slave_memory, serialises read words back under a ready/valid
// handshake, and pulses tx_done for one cycle when a transaction finishes.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   slave_select      bus select for this slave (low in a busy state = abort)
//   master_valid      master drives a valid rx_* bit this cycle
//   master_ready      master accepts the tx_data bit this cycle
//   write_en/read_en  direction request, sampled only at start
//   rx_address        serial address
//   rx_burst_number   serial burst count, alongside the first address bits
//   rx_data           serial write data
//   slave_ready       idle and able to accept a transaction
//   slave_valid       tx_data carries a valid read bit
//   tx_data           serial read data
//   tx_done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_LEN  = BUS_ADDR_LEN,
    parameter int DATA_LEN  = BUS_DATA_LEN,
    parameter int BURST_LEN = BUS_BURST_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic slave_select,
    input  logic master_valid,
    input  logic master_ready,
    input  logic write_en,
    input  logic read_en,
    input  logic rx_address,
    input  logic rx_burst_number,
    input  logic rx_data,
    output logic slave_ready,
    output logic slave_valid,
    output logic tx_data,
    output logic tx_done
);

    localparam int IDX_MAX = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int IDX_W   = $clog2(IDX_MAX);
    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_LEN - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_LEN - 1);

    logic [2:0]           r_state;
    dir_e                 r_dir;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [ADDR_LEN-1:0]  r_addr;
    logic [BURST_LEN-1:0] r_burst;
    logic [BURST_LEN-1:0] r_word_cnt;
    logic [DATA_LEN-1:0]  r_word;
    logic [DATA_LEN-1:0]  r_tx_word;
    logic                 r_wr_pending;
    logic [ADDR_LEN-1:0]  r_wr_addr;
    logic [DATA_LEN-1:0]  r_wr_data;

    logic                 w_start;
    logic                 w_abort;
    logic [ADDR_LEN-1:0]  w_addr_shift;
    logic [BURST_LEN-1:0] w_burst_shift;
    logic                 w_burst_take;
    logic [BURST_LEN-1:0] w_burst_final;
    logic [DATA_LEN-1:0]  w_word_shift;
    logic [DATA_LEN-1:0]  w_tx_shift;
    logic                 w_addr_done;
    logic                 w_last_accept;
    logic                 w_rd_en;
    logic [ADDR_LEN-1:0]  w_rd_addr;
    logic [ADDR_LEN-1:0]  w_mem_addr;
    logic [DATA_LEN-1:0]  w_mem_rdata;

    assign w_start = bus_start(slave_select, master_valid, write_en, read_en);
    assign w_abort = (r_state != S_IDLE) && !slave_select;

    // Serial fields enter at the MSB end of a shift register, so after exactly
    // N shifts the first (LSB) bit has arrived at bit 0.
    assign w_addr_shift  = (r_addr >> 1) | (ADDR_LEN'(rx_address) << (ADDR_LEN - 1));
    assign w_burst_shift = (r_burst >> 1) | (BURST_LEN'(rx_burst_number) << (BURST_LEN - 1));
    assign w_word_shift  = (r_word >> 1) | (DATA_LEN'(rx_data) << (DATA_LEN - 1));
    assign w_tx_shift    = r_tx_word >> 1;

    // Burst bits ride along with the first BURST_LEN address bits only.
    assign w_burst_take  = int'(r_bit_idx) < BURST_LEN;
    assign w_burst_final = w_burst_take ? w_burst_shift : r_burst;

    assign w_addr_done   = (r_state == S_ADDR) && slave_select && master_valid
                           && (r_bit_idx == ADDR_LAST);
    assign w_last_accept = (r_state == S_RDATA) && slave_select && master_ready
                           && (r_bit_idx == DATA_LAST);

    // Read issue: the RAM is addressed in the cycle that moves the FSM into
    // RFETCH, so RFETCH sees the fetched word and RDATA starts with a
    // registered tx_data. That gives N+2 / M+2 to the first valid bit.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_addr;
        if (w_addr_done && (r_dir == DIR_READ)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_addr_shift;
        end else if (w_last_accept && (r_word_cnt != '0)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_addr + ADDR_LEN'(1);
        end else begin
            w_rd_en   = 1'b0;
            w_rd_addr = r_addr;
        end
    end

    // A committing write owns the single RAM port; reads never overlap it.
    assign w_mem_addr = r_wr_pending ? r_wr_addr : w_rd_addr;

    slave_memory #(
        .ADDR_LEN (ADDR_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_mem (
        .clk     (clk),
        .i_we    (r_wr_pending),
        .i_re    (w_rd_en),
        .i_addr  (w_mem_addr),
        .i_wdata (r_wr_data),
        .o_rdata (w_mem_rdata)
    );

    // Transaction FSM, deserialisers, read serialiser and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dir        <= DIR_WRITE;
            r_bit_idx    <= '0;
            r_addr       <= '0;
            r_burst      <= '0;
            r_word_cnt   <= '0;
            r_word       <= '0;
            r_tx_word    <= '0;
            r_wr_pending <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            slave_ready  <= 1'b1;
            slave_valid  <= 1'b0;
            tx_data      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            // The write strobe lives for exactly one cycle; an abort does not
            // cancel a word that is already committing.
            r_wr_pending <= 1'b0;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_bit_idx   <= '0;
                slave_ready <= 1'b1;
                slave_valid <= 1'b0;
                tx_data     <= 1'b0;
                tx_done     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_addr      <= w_addr_shift;
                            r_burst     <= w_burst_shift;
                            r_dir       <= read_en ? DIR_READ : DIR_WRITE;
                            r_bit_idx   <= IDX_W'(1);
                            slave_ready <= 1'b0;
                            r_state     <= S_ADDR;
                        end else begin
                            slave_ready <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (master_valid) begin
                            r_addr <= w_addr_shift;
                            if (w_burst_take) begin
                                r_burst <= w_burst_shift;
                            end
                            if (r_bit_idx == ADDR_LAST) begin
                                r_bit_idx  <= '0;
                                r_word_cnt <= w_burst_final;
                                r_state    <= (r_dir == DIR_READ) ? S_RFETCH : S_WDATA;
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                            end
                        end
                    end
                    S_WDATA: begin
                        if (master_valid) begin
                            r_word <= w_word_shift;
                            if (r_bit_idx == DATA_LAST) begin
                                r_wr_pending <= 1'b1;
                                r_wr_addr    <= r_addr;
                                r_wr_data    <= w_word_shift;
                                r_addr       <= r_addr + ADDR_LEN'(1);
                                r_bit_idx    <= '0;
                                if (r_word_cnt == '0) begin
                                    r_state <= S_DONE;
                                    tx_done <= 1'b1;
                                end else begin
                                    r_word_cnt <= r_word_cnt - BURST_LEN'(1);
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                            end
                        end
                    end
                    S_RFETCH: begin
                        r_tx_word   <= w_mem_rdata;
                        tx_data     <= w_mem_rdata[0];
                        slave_valid <= 1'b1;
                        r_bit_idx   <= '0;
                        r_state     <= S_RDATA;
                    end
                    S_RDATA: begin
                        if (master_ready) begin
                            if (r_bit_idx == DATA_LAST) begin
                                slave_valid <= 1'b0;
                                tx_data     <= 1'b0;
                                r_bit_idx   <= '0;
                                if (r_word_cnt == '0) begin
                                    r_state <= S_DONE;
                                    tx_done <= 1'b1;
                                end else begin
                                    r_word_cnt <= r_word_cnt - BURST_LEN'(1);
                                    r_addr     <= r_addr + ADDR_LEN'(1);
                                    r_state    <= S_RFETCH;
                                end
                            end else begin
                                r_tx_word <= w_tx_shift;
                                tx_data   <= w_tx_shift[0];
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        tx_done     <= 1'b0;
                        slave_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_bit_idx   <= '0;
                        slave_ready <= 1'b1;
                        slave_valid <= 1'b0;
                        tx_data     <= 1'b0;
                        tx_done     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slave_port.sv
// -----------------------------------------------------------------------------
// tb_slave_port
// Self-checking bench for slave_port. A plain array models the slave memory:
// a write of burst b at address a stores b+1 words at (a+k) mod 4096, and a
// read must stream those words back LSB first with the documented latencies.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_slave_port;

    logic clk = 1'b0;
    logic reset, slave_select, master_valid, master_ready;
    logic write_en, read_en, rx_address, rx_burst_number, rx_data;
    logic slave_ready, slave_valid, tx_data, tx_done;

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;

    logic [7:0] model_mem [0:4095];

    always #5 clk = ~clk;

    slave_port dut (
        .clk             (clk),
        .reset           (reset),
        .slave_select    (slave_select),
        .master_valid    (master_valid),
        .master_ready    (master_ready),
        .write_en        (write_en),
        .read_en         (read_en),
        .rx_address      (rx_address),
        .rx_burst_number (rx_burst_number),
        .rx_data         (rx_data),
        .slave_ready     (slave_ready),
        .slave_valid     (slave_valid),
        .tx_data         (tx_data),
        .tx_done         (tx_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tx_done === 1'b1) done_seen++;
    endtask

    task automatic idle_inputs();
        slave_select = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
        write_en = 1'b0; read_en = 1'b0;
        rx_address = 1'b0; rx_burst_number = 1'b0; rx_data = 1'b0;
    endtask

    // Drives the 12 address bits (burst bits on the first 4); returns at N+1.
    task automatic drive_header(input logic [11:0] a, input logic [3:0] bn,
                                input bit rd, input bit stall);
        logic [11:0] sa;
        logic [3:0]  sb;
        sa = a; sb = bn;
        for (int i = 0; i < 12; i++) begin
            if (i > 0 && stall && $urandom_range(0, 3) == 0) begin
                master_valid = 1'b0;
                rx_address = 1'($urandom_range(0, 1));
                rx_burst_number = 1'($urandom_range(0, 1));
                step();
            end
            slave_select = 1'b1;
            master_valid = 1'b1;
            if (i == 0) begin
                write_en = !rd; read_en = rd;
            end else begin
                write_en = 1'($urandom_range(0, 1));
                read_en  = 1'($urandom_range(0, 1));
            end
            rx_address = sa[0];
            rx_burst_number = (i < 4) ? sb[0] : 1'($urandom_range(0, 1));
            sa = sa >> 1; sb = sb >> 1;
            step();
        end
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] bn,
                            input logic [7:0] d [16], input bit stall);
        logic [7:0]  sd;
        logic [11:0] wa;
        done_seen = 0;
        drive_header(a, bn, 1'b0, stall);
        for (int k = 0; k <= int'(bn); k++) begin
            sd = d[k];
            for (int b = 0; b < 8; b++) begin
                if (stall && $urandom_range(0, 3) == 0) begin
                    master_valid = 1'b0;
                    rx_data = 1'($urandom_range(0, 1));
                    step();
                end
                master_valid = 1'b1;
                rx_data = sd[0];
                sd = sd >> 1;
                write_en = 1'($urandom_range(0, 1));
                read_en  = 1'($urandom_range(0, 1));
                step();
            end
            wa = a + 12'(k);
            model_mem[wa] = d[k];
        end
        master_valid = 1'b0;
        checks++;
        if (tx_done !== 1'b1) begin
            errors++; $display("FAIL wr_done_pulse: got %b want 1", tx_done);
        end
        checks++;
        if (slave_ready !== 1'b0) begin
            errors++; $display("FAIL wr_busy_in_done: got %b want 0", slave_ready);
        end
        step();
        checks++;
        if (slave_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++; $display("FAIL wr_after_done: ready=%b done=%b want 1/0", slave_ready, tx_done);
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL wr_done_count: got %0d want 1", done_seen);
        end
        idle_inputs();
        step();
    endtask

    // mode 0: master_ready toggles 1,0,1,0; mode 1: random; mode 2: always 1
    task automatic do_read(input logic [11:0] a, input logic [3:0] bn,
                           input int mode, input bit stall);
        logic [7:0]  exp_sh;
        logic [11:0] ra;
        bit          r, tgl, accepted;
        int          zeros;
        done_seen = 0; tgl = 1'b1; zeros = 0;
        drive_header(a, bn, 1'b1, stall);
        master_valid = 1'b0;
        master_ready = 1'($urandom_range(0, 1));
        checks++;
        if (slave_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_early: got %b want 0 at N+1", slave_valid);
        end
        step();
        for (int k = 0; k <= int'(bn); k++) begin
            ra = a + 12'(k);
            exp_sh = model_mem[ra];
            checks++;
            if (slave_valid !== 1'b1) begin
                errors++; $display("FAIL rd_valid_start: word %0d got %b want 1", k, slave_valid);
            end
            for (int b = 0; b < 8; b++) begin
                accepted = 1'b0;
                for (int g = 0; g < 8 && !accepted; g++) begin
                    if (mode == 0) begin
                        r = tgl; tgl = !tgl;
                    end else if (mode == 1) begin
                        r = 1'($urandom_range(0, 1));
                        if (zeros >= 3) r = 1'b1;
                    end else begin
                        r = 1'b1;
                    end
                    zeros = r ? 0 : zeros + 1;
                    master_ready = r;
                    checks++;
                    if (slave_valid !== 1'b1 || tx_data !== exp_sh[0]) begin
                        errors++;
                        $display("FAIL rd_bit: addr %h bit %0d valid=%b data=%b want 1/%b",
                                 ra, b, slave_valid, tx_data, exp_sh[0]);
                    end
                    step();
                    if (r) accepted = 1'b1;
                end
                exp_sh = exp_sh >> 1;
            end
            master_ready = 1'($urandom_range(0, 1));
            checks++;
            if (slave_valid !== 1'b0) begin
                errors++; $display("FAIL rd_word_gap: got %b want 0", slave_valid);
            end
            if (k == int'(bn)) begin
                checks++;
                if (tx_done !== 1'b1) begin
                    errors++; $display("FAIL rd_done_pulse: got %b want 1", tx_done);
                end
            end
            step();
        end
        checks++;
        if (slave_ready !== 1'b1 || tx_done !== 1'b0) begin
            errors++; $display("FAIL rd_after_done: ready=%b done=%b want 1/0", slave_ready, tx_done);
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL rd_done_count: got %0d want 1", done_seen);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0 || tx_data !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%b done=%b want 1/0/0/0",
                     slave_ready, slave_valid, tx_data, tx_done);
        end
    endtask

    task automatic test_both_enables();
        for (int i = 0; i < 6; i++) begin
            slave_select = 1'b1; master_valid = 1'b1;
            write_en = 1'b1; read_en = 1'b1;
            rx_address = 1'($urandom_range(0, 1));
            rx_burst_number = 1'($urandom_range(0, 1));
            rx_data = 1'($urandom_range(0, 1));
            step();
            checks++;
            if (slave_ready !== 1'b1 || dut.u_mem.i_we !== 1'b0) begin
                errors++; $display("FAIL both_en_ignored: ready=%b we=%b want 1/0", slave_ready, dut.u_mem.i_we);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_write_burst();
        logic [7:0] d [16];
        logic [7:0] got;
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h81;
        for (int k = 3; k < 16; k++) d[k] = 8'h00;
        do_write(12'h0F0, 4'd2, d, 1'b0);
        for (int k = 0; k < 3; k++) begin
            got = dut.u_mem.r_mem[12'h0F0 + 12'(k)];
            checks++;
            if (got !== d[k]) begin
                errors++; $display("FAIL wr_mem_content: addr %h got %h want %h", 12'h0F0 + 12'(k), got, d[k]);
            end
        end
    endtask

    task automatic test_read_burst();
        do_read(12'h0F0, 4'd2, 0, 1'b0);
    endtask

    task automatic test_wrap();
        logic [7:0] d [16];
        logic [7:0] got;
        for (int k = 0; k < 16; k++) d[k] = 8'h00;
        d[0] = 8'h11; d[1] = 8'h22;
        do_write(12'hFFF, 4'd1, d, 1'b0);
        got = dut.u_mem.r_mem[12'hFFF];
        checks++;
        if (got !== 8'h11) begin
            errors++; $display("FAIL wrap_fff: got %h want 11", got);
        end
        got = dut.u_mem.r_mem[12'h000];
        checks++;
        if (got !== 8'h22) begin
            errors++; $display("FAIL wrap_000: got %h want 22", got);
        end
        do_read(12'hFFF, 4'd1, 1, 1'b1);
    endtask

    task automatic test_abort();
        logic [7:0] d [16];
        logic [7:0] sd, got;
        for (int k = 0; k < 16; k++) d[k] = 8'h00;
        d[0] = 8'h5A;
        do_write(12'h011, 4'd0, d, 1'b0);
        d[0] = 8'hC3; d[1] = 8'h7E;
        done_seen = 0;
        drive_header(12'h010, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sd = d[k];
            for (int b = 0; b < ((k == 0) ? 8 : 4); b++) begin
                master_valid = 1'b1; rx_data = sd[0]; sd = sd >> 1;
                step();
            end
        end
        model_mem[12'h010] = d[0];
        slave_select = 1'b0; master_valid = 1'b0;
        step();
        checks++;
        if (slave_ready !== 1'b1) begin
            errors++; $display("FAIL abort_ready: got %b want 1", slave_ready);
        end
        repeat (3) step();
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d want 0", done_seen);
        end
        got = dut.u_mem.r_mem[12'h010];
        checks++;
        if (got !== model_mem[12'h010]) begin
            errors++; $display("FAIL abort_first_word: got %h want %h", got, model_mem[12'h010]);
        end
        got = dut.u_mem.r_mem[12'h011];
        checks++;
        if (got !== model_mem[12'h011]) begin
            errors++; $display("FAIL abort_second_word: got %h want %h", got, model_mem[12'h011]);
        end
        do_read(12'h010, 4'd1, 2, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d [16];
        for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
        do_write(12'h300, 4'd1, d, 1'b0);
        drive_header(12'h300, 4'd1, 1'b1, 1'b0);
        master_valid = 1'b0; master_ready = 1'b0;
        step();
        master_ready = 1'b1;
        repeat (4) step();
        checks++;
        if (slave_valid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_setup: valid=%b want 1", slave_valid);
        end
        reset = 1'b1; idle_inputs();
        step();
        reset = 1'b0;
        checks++;
        if (slave_valid !== 1'b0 || slave_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state: valid=%b ready=%b want 0/1", slave_valid, slave_ready);
        end
        step();
        do_read(12'h300, 4'd1, 1, 1'b0);
    endtask

    task automatic test_random_traffic();
        logic [7:0]  d [16];
        logic [11:0] a;
        logic [3:0]  bn;
        for (int t = 0; t < 5; t++) begin
            a  = 12'($urandom);
            bn = 4'($urandom);
            for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
            do_write(a, bn, d, 1'b1);
            do_read(a, bn, 1, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_both_enables();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Bit-serial slave-side endpoint of the system bus. Sits directly downstream of master_port.
- Deserialises the address, burst count and write data that the master shifts out, and executes single or burst writes into a local memory.
- For reads, serialises memory words back to the master under a ready/valid handshake.
- Reports completion to the master with a one-cycle done pulse.

Parameters:
- ADDR_LEN, 12, address width; local memory depth is 2^ADDR_LEN words.
- DATA_LEN, 8, word width in bits.
- BURST_LEN, 4, burst-count field width; a transaction moves burst+1 words. Constraint: BURST_LEN <= ADDR_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- slave_select  in  1  decoded select for this slave from the bus.
- master_valid  in  1  master drives a valid bit on rx_address/rx_burst_number/rx_data this cycle.
- master_ready  in  1  master accepts the bit on tx_data this cycle.
- write_en  in  1  write transaction request.
- read_en  in  1  read transaction request.
- rx_address  in  1  serial address, LSB first.
- rx_burst_number  in  1  serial burst count, LSB first; shifted in parallel with the address.
- rx_data  in  1  serial write data, LSB first.
- slave_ready  out  1  slave idle and able to accept a transaction.
- slave_valid  out  1  tx_data carries a valid read bit.
- tx_data  out  1  serial read data, LSB first.
- tx_done  out  1  one-cycle pulse when a transaction completes.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (reset).
- All outputs are registered.
- Reset state: IDLE, slave_ready=1, slave_valid=0, tx_data=0, tx_done=0; all counters and shift registers cleared.
- States: IDLE, ADDR, WDATA, RFETCH, RDATA, DONE.
- IDLE:
  - Start condition: slave_select & master_valid & (write_en ^ read_en).
  - On start, capture address bit 0 and burst bit 0, latch the direction, clear slave_ready, and go to ADDR.
  - write_en & read_en both high: ignored; stay in IDLE.
- ADDR:
  - Each cycle with master_valid=1 shifts in one address bit and, while the bit index < BURST_LEN, one burst bit.
  - master_valid=0 stalls the phase with no shift.
  - After ADDR_LEN bits, load word_cnt = burst and go to WDATA (write) or RFETCH (read).
- WDATA:
  - Each master_valid=1 cycle shifts one rx_data bit into the word register.
  - When bit DATA_LEN-1 is captured (cycle M), the word commits to memory at the current address at the end of cycle M+1.
  - Address increments modulo 2^ADDR_LEN.
  - If word_cnt == 0, go to DONE at M+1; otherwise decrement word_cnt and continue. Bit 0 of the next word may arrive at M+1.
- RFETCH:
  - Issue the memory read (1-cycle latency), then go to RDATA.
- RDATA:
  - Entry: tx_data = bit 0 of the fetched word, slave_valid = 1.
  - Advance one bit per cycle only when master_ready = 1; with master_ready = 0, tx_data and slave_valid hold.
  - After the last bit is accepted, do one of the following:
    - word_cnt == 0: go to DONE with slave_valid = 0.
    - otherwise: decrement word_cnt, increment the address (with wrap), and go to RFETCH.
- Read latency: last address bit captured at cycle N → first slave_valid at N+2. Between words: last bit accepted at M → next bit 0 valid at M+2.
- DONE: tx_done = 1 for exactly one cycle, then IDLE with slave_ready = 1 the following cycle.
- Abort: slave_select = 0 in any non-IDLE state returns to IDLE the next cycle.
  - A write already pending commit completes; no further writes occur.
  - tx_done is not pulsed; slave_valid drops to 0.
- Mid-phase changes: write_en/read_en changes after start are ignored.
- Reset mid-transaction: returns to the reset state; memory contents are not cleared.

Decomposition:
- bus_pkg: state encoding, default ADDR_LEN/DATA_LEN/BURST_LEN, direction enum (DIR_WRITE, DIR_READ).
- Sub-module slave_memory: single-port synchronous RAM, 2^ADDR_LEN x DATA_LEN, registered write, 1-cycle registered read. Instantiated once inside slave_port.

Test Plan:
- Reset then idle → slave_ready=1, slave_valid=0, tx_done=0; asserting both write_en and read_en with master_valid keeps slave_ready=1 and no memory write.
- Write addr 0x0F0, burst 2, data 0xA5,0x3C,0x81, continuous master_valid → memory[0x0F0..0x0F2] = A5,3C,81; tx_done pulses once, 1 cycle after the last data bit; slave_ready=1 the next cycle.
- Read addr 0x0F0, burst 2, master_ready toggled 1,0,1,0 → serial stream LSB-first reproduces A5,3C,81; first slave_valid at N+2; held bits are stable during master_ready=0; one tx_done.
- Wrap: write addr 0xFFF, burst 1, data 0x11,0x22 → memory[0xFFF]=0x11, memory[0x000]=0x22.
- Abort: drop slave_select after 4 bits of the second write word (burst 1, addr 0x010) → memory[0x010] written, memory[0x011] unchanged, no tx_done, slave_ready=1 the next cycle.
- Reset asserted mid-RDATA → slave_valid=0 and slave_ready=1 the cycle after reset; a subsequent read returns correct data.
